// File: rtl/sum_operand_packer.sv
// Byte-stream to LANES-wide operand packer feeding the four-input adder stage.
// Flush zero-pads a partial group so downstream always sees complete vectors.
module sum_operand_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          x_o [LANES],
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(LANES)-1:0]   lane_cnt_o,
  output logic [CNT_W-1:0]           group_cnt_o
);
  localparam int PTR_W = $clog2(LANES);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

  typedef enum logic {S_FILL, S_FLUSH} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_asm [LANES];
  logic [DATA_W-1:0]  r_x   [LANES];
  logic               r_out_valid;
  logic [PTR_W-1:0]   r_p;
  logic [CNT_W-1:0]   r_grp;

  logic w_slot_free;
  logic w_last;
  logic w_accept;

  // The slot counts as free when the held vector is being drained this same cycle.
  assign w_slot_free = !r_out_valid || out_ready_i;
  assign w_last      = (r_p == LAST);
  assign in_ready_o  = rst_ni && (r_state == S_FILL) && !(w_last && !w_slot_free);
  assign w_accept    = in_valid_i && in_ready_o;

  assign x_o         = r_x;
  assign out_valid_o = r_out_valid;
  assign lane_cnt_o  = r_p;
  assign group_cnt_o = r_grp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_FILL;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_grp       <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_asm[i] <= '0;
        r_x[i]   <= '0;
      end
    end else if (r_state == S_FILL) begin
      if (w_accept && w_last) begin
        // Final byte bypasses the assembly register straight into the top lane.
        for (int i = 0; i < LANES; i++) begin
          r_x[i]   <= (i == LANES - 1) ? in_data_i : r_asm[i];
          r_asm[i] <= '0;
        end
        r_out_valid <= 1'b1;
        r_p         <= '0;
        r_grp       <= r_grp + CNT_W'(1);
      end else begin
        if (w_accept) begin
          r_asm[r_p] <= in_data_i;
          r_p        <= r_p + PTR_W'(1);
        end
        if (flush_i && (w_accept || (r_p != '0))) begin
          r_state <= S_FLUSH;
        end
        if (out_ready_i) begin
          r_out_valid <= 1'b0;
        end
      end
    end else if (w_slot_free) begin
      // Unfilled lanes are already zero, so the padded vector is the assembly as-is.
      for (int i = 0; i < LANES; i++) begin
        r_x[i]   <= r_asm[i];
        r_asm[i] <= '0;
      end
      r_out_valid <= 1'b1;
      r_p         <= '0;
      r_grp       <= r_grp + CNT_W'(1);
      r_state     <= S_FILL;
    end
  end
endmodule
